// File: rtl/bp2wb_pkg.sv
// Shared definitions for the BP-to-Wishbone bridge slice: arbiter FSM states,
// requester port indices, and default sizing constants.
package bp2wb_pkg;

  // Arbiter FSM states: accept a command, hand it downstream, await response
  typedef enum logic [1:0] {
    e_arb_idle = 2'd0,
    e_arb_send = 2'd1,
    e_arb_wait = 2'd2
  } bp_arb_state_e;

  // Default number of cycles allowed between downstream handoff and response
  localparam int unsigned timeout_cycles_gp = 4096;

  // Default width of one cce mem message (header + data) as seen by the bridge
  localparam int unsigned cce_mem_msg_width_gp = 64;

  // Requester port indices
  localparam logic port_core_gp = 1'b0;
  localparam logic port_io_gp   = 1'b1;

endpackage

// File: rtl/bp_mem_rr_arb2.sv
// Two-input round-robin grant. The grant is purely combinational from the
// current valids; the last_grant history only advances when the owner of the
// block reports that the grant was actually accepted.
module bp_mem_rr_arb2
  import bp2wb_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] v_i,
  input  logic       en_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o
);

  logic last_grant_r;

  // Contention goes to the port that did not win last; otherwise the lone valid port
  assign grant_idx_o = (v_i == 2'b11) ? ~last_grant_r : v_i[1];

  // One-hot grant, only while the arbiter is allowed to hand out grants
  always_comb begin
    grant_o = 2'b00;
    if (en_i && v_i[grant_idx_o]) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

  // History starts at the I/O port so the core wins the first contention
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant_r <= port_io_gp;
    end else if (accept_i) begin
      last_grant_r <= grant_idx_o;
    end
  end

endmodule

// File: rtl/bp_mem_cmd_arbiter.sv
// Merges the BP core memory port and the BP I/O port onto the single cce mem
// cmd/resp channel feeding bp2wb_convertor. One transaction is in flight at a
// time; the response is steered back to whichever port issued the command.
// A sticky watchdog flags a downstream access that never responds.
module bp_mem_cmd_arbiter
  import bp2wb_pkg::*;
#(
  parameter int cce_mem_msg_width_p = cce_mem_msg_width_gp,
  parameter int timeout_cycles_p    = timeout_cycles_gp,
  localparam int timeout_ctr_width_lp = $clog2(timeout_cycles_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,

  input  logic [1:0][cce_mem_msg_width_p-1:0] mem_cmd_i,
  input  logic [1:0]                          mem_cmd_v_i,
  output logic [1:0]                          mem_cmd_ready_o,

  output logic [cce_mem_msg_width_p-1:0]      mem_resp_o,
  output logic [1:0]                          mem_resp_v_o,
  input  logic [1:0]                          mem_resp_yumi_i,

  output logic [cce_mem_msg_width_p-1:0]      mem_cmd_o,
  output logic                                mem_cmd_v_o,
  input  logic                                mem_cmd_ready_i,

  input  logic [cce_mem_msg_width_p-1:0]      mem_resp_i,
  input  logic                                mem_resp_v_i,
  output logic                                mem_resp_yumi_o,

  output logic                                timeout_o
);

  localparam logic [timeout_ctr_width_lp-1:0] ctr_max_lp  = timeout_ctr_width_lp'(timeout_cycles_p);
  localparam logic [timeout_ctr_width_lp-1:0] ctr_last_lp = timeout_ctr_width_lp'(timeout_cycles_p - 1);

  bp_arb_state_e                   state_r;
  logic                            owner_r;
  logic [cce_mem_msg_width_p-1:0]  cmd_r;
  logic [timeout_ctr_width_lp-1:0] ctr_r;
  logic                            timeout_r;

  logic [1:0] arb_grant;
  logic       arb_grant_idx;
  logic       arb_en;
  logic       cmd_accept;

  // Grants are only offered while idle and never while reset is held
  assign arb_en     = (state_r == e_arb_idle) && !reset_i;
  assign cmd_accept = |arb_grant;

  bp_mem_rr_arb2 arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (mem_cmd_v_i),
    .en_i        (arb_en),
    .accept_i    (cmd_accept),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_grant_idx)
  );

  assign mem_cmd_o  = cmd_r;
  assign mem_resp_o = mem_resp_i;
  assign timeout_o  = timeout_r;

  // Handshake signalling: downstream valid mirrors ready because the convertor latches on valid alone
  always_comb begin
    mem_cmd_ready_o = arb_grant;
    mem_cmd_v_o     = (state_r == e_arb_send) && mem_cmd_ready_i;
    mem_resp_v_o    = 2'b00;
    mem_resp_yumi_o = 1'b0;
    if (state_r == e_arb_wait) begin
      mem_resp_v_o[owner_r] = mem_resp_v_i;
      mem_resp_yumi_o       = mem_resp_v_i && mem_resp_yumi_i[owner_r];
    end
  end

  // Transaction FSM with command register, owner tracking and saturating watchdog
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= e_arb_idle;
      owner_r   <= port_core_gp;
      cmd_r     <= '0;
      ctr_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        e_arb_idle: begin
          if (cmd_accept) begin
            cmd_r   <= mem_cmd_i[arb_grant_idx];
            owner_r <= arb_grant_idx;
            state_r <= e_arb_send;
          end
        end
        e_arb_send: begin
          if (mem_cmd_v_o) begin
            ctr_r   <= '0;
            state_r <= e_arb_wait;
          end
        end
        e_arb_wait: begin
          if (ctr_r != ctr_max_lp) begin
            ctr_r <= ctr_r + timeout_ctr_width_lp'(1);
            if (ctr_r == ctr_last_lp) begin
              timeout_r <= 1'b1;
            end
          end
          if (mem_resp_yumi_o) begin
            state_r <= e_arb_idle;
          end
        end
        default: begin
          state_r <= e_arb_idle;
        end
      endcase
    end
  end

  // A response arriving with no access outstanding is a downstream protocol error
  spurious_resp_a : assert property (@(posedge clk_i) disable iff (reset_i)
                                     mem_resp_v_i |-> (state_r == e_arb_wait));

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Self-checking bench for bp_mem_cmd_arbiter. A transaction-level model tracks
// the round-robin history, the owner of each access, and the watchdog age.
module tb_bp_mem_cmd_arbiter;
  import bp2wb_pkg::*;

  localparam int W  = 64;
  localparam int TO = 16;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [1:0][W-1:0] mem_cmd_i;
  logic [1:0]        mem_cmd_v_i;
  logic [1:0]        mem_cmd_ready_o;
  logic [W-1:0]      mem_resp_o;
  logic [1:0]        mem_resp_v_o;
  logic [1:0]        mem_resp_yumi_i;
  logic [W-1:0]      mem_cmd_o;
  logic              mem_cmd_v_o;
  logic              mem_cmd_ready_i;
  logic [W-1:0]      mem_resp_i;
  logic              mem_resp_v_i;
  logic              mem_resp_yumi_o;
  logic              timeout_o;

  bp_mem_cmd_arbiter #(
    .cce_mem_msg_width_p (W),
    .timeout_cycles_p    (TO)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i),
    .mem_cmd_o       (mem_cmd_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .mem_resp_i      (mem_resp_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_yumi_o (mem_resp_yumi_o),
    .timeout_o       (timeout_o)
  );

  // 10-unit clock period
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  int model_last;
  bit model_to;
  bit model_in_wait;
  int model_wait_age;

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and age the model's outstanding access
  task automatic next_cycle();
    @(posedge clk_i);
    #2;
    if (model_in_wait) begin
      model_wait_age++;
      if (model_wait_age >= TO) model_to = 1'b1;
    end
  endtask

  function automatic int expect_grant(input logic [1:0] req);
    if (req == 2'b11) return 1 - model_last;
    return req[1] ? 1 : 0;
  endfunction

  // One full transaction: arbitration, optional downstream stall, optional
  // response delay, optional owner-yumi stall with a non-owner yumi asserted
  task automatic apply_stimulus(input logic [1:0] req, input int cmd_stall,
                                input int resp_delay, input int resp_stall,
                                input bit other_yumi);
    logic [1:0][W-1:0] cmds;
    logic [W-1:0]      resp;
    int                g;
    cmds[0] = {$urandom, $urandom};
    cmds[1] = {$urandom, $urandom};
    g = expect_grant(req);

    mem_cmd_i       = cmds;
    mem_cmd_v_i     = req;
    mem_cmd_ready_i = 1'($urandom_range(0, 1));
    #1;
    check_output("idle_cmd_ready", W'(mem_cmd_ready_o), W'(1) << g);
    check_output("idle_cmd_v", W'(mem_cmd_v_o), W'(0));
    next_cycle();
    model_last = g;

    mem_cmd_i       = {{$urandom, $urandom}, {$urandom, $urandom}};
    mem_cmd_ready_i = 1'b0;
    for (int i = 0; i < cmd_stall; i++) begin
      #1;
      check_output("send_stall_cmd_v", W'(mem_cmd_v_o), W'(0));
      next_cycle();
    end
    mem_cmd_ready_i = 1'b1;
    #1;
    check_output("send_cmd_v", W'(mem_cmd_v_o), W'(1));
    check_output("send_cmd_data", mem_cmd_o, cmds[g]);
    check_output("send_cmd_ready", W'(mem_cmd_ready_o), W'(0));
    next_cycle();
    model_in_wait  = 1'b1;
    model_wait_age = 0;

    for (int i = 0; i < resp_delay; i++) begin
      #1;
      check_output("wait_cmd_v", W'(mem_cmd_v_o), W'(0));
      check_output("wait_resp_v_idle", W'(mem_resp_v_o), W'(0));
      check_output("wait_timeout", W'(timeout_o), W'(model_to));
      next_cycle();
    end

    resp         = {$urandom, $urandom};
    mem_resp_i   = resp;
    mem_resp_v_i = 1'b1;
    for (int i = 0; i < resp_stall; i++) begin
      mem_resp_yumi_i        = 2'b00;
      mem_resp_yumi_i[1 - g] = other_yumi;
      #1;
      check_output("stall_resp_v", W'(mem_resp_v_o), W'(1) << g);
      check_output("stall_resp_yumi", W'(mem_resp_yumi_o), W'(0));
      next_cycle();
    end
    mem_resp_yumi_i        = 2'b00;
    mem_resp_yumi_i[g]     = 1'b1;
    mem_resp_yumi_i[1 - g] = 1'($urandom_range(0, 1));
    #1;
    check_output("resp_v", W'(mem_resp_v_o), W'(1) << g);
    check_output("resp_yumi", W'(mem_resp_yumi_o), W'(1));
    check_output("resp_data", mem_resp_o, resp);
    check_output("resp_timeout", W'(timeout_o), W'(model_to));
    next_cycle();
    model_in_wait   = 1'b0;
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;
    mem_cmd_v_i     = 2'b00;
  endtask

  initial begin
    logic [1:0] req;
    model_last      = 1;
    model_to        = 1'b0;
    model_in_wait   = 1'b0;
    model_wait_age  = 0;
    reset_i         = 1'b1;
    mem_cmd_i       = '0;
    mem_cmd_v_i     = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_i      = '0;
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;

    // Reset holds every handshake output low even with requests pending
    #3;
    check_output("reset_cmd_ready", W'(mem_cmd_ready_o), W'(0));
    check_output("reset_cmd_v", W'(mem_cmd_v_o), W'(0));
    check_output("reset_resp_v", W'(mem_resp_v_o), W'(0));
    check_output("reset_timeout", W'(timeout_o), W'(0));
    mem_cmd_v_i = 2'b00;
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    next_cycle();

    $display("[TB] single request");
    apply_stimulus(2'b01, 0, 0, 0, 1'b0);

    $display("[TB] contention");
    for (int i = 0; i < 4; i++) apply_stimulus(2'b11, 0, 1, 0, 1'b0);

    $display("[TB] downstream backpressure");
    apply_stimulus(2'b10, 10, 0, 0, 1'b0);

    $display("[TB] response stall with non-owner yumi");
    apply_stimulus(2'b01, 0, 0, 3, 1'b1);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 20; i++) begin
      req = 2'($urandom_range(1, 3));
      apply_stimulus(req, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] watchdog timeout");
    apply_stimulus(2'b01, 0, 30, 0, 1'b0);
    apply_stimulus(2'b10, 0, 0, 0, 1'b0);

    $display("[TB] async reset mid-wait");
    mem_cmd_i       = {{$urandom, $urandom}, {$urandom, $urandom}};
    mem_cmd_v_i     = 2'b01;
    mem_cmd_ready_i = 1'b1;
    next_cycle();
    mem_cmd_v_i = 2'b00;
    next_cycle();
    model_in_wait  = 1'b1;
    model_wait_age = 0;
    next_cycle();
    next_cycle();
    mem_cmd_v_i     = 2'b11;
    mem_resp_v_i    = 1'b1;
    mem_resp_yumi_i = 2'b11;
    #1;
    check_output("pre_reset_resp_v", W'(mem_resp_v_o), W'(1));
    check_output("pre_reset_timeout", W'(timeout_o), W'(model_to));
    reset_i = 1'b1;
    #1;
    model_in_wait = 1'b0;
    model_to      = 1'b0;
    model_last    = 1;
    check_output("midreset_cmd_ready", W'(mem_cmd_ready_o), W'(0));
    check_output("midreset_cmd_v", W'(mem_cmd_v_o), W'(0));
    check_output("midreset_resp_v", W'(mem_resp_v_o), W'(0));
    check_output("midreset_resp_yumi", W'(mem_resp_yumi_o), W'(0));
    check_output("midreset_timeout", W'(timeout_o), W'(0));
    mem_cmd_v_i     = 2'b00;
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    next_cycle();
    apply_stimulus(2'b10, 0, 0, 0, 1'b0);
    apply_stimulus(2'b11, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bp_mem_cmd_arbiter.md
Name: bp_mem_cmd_arbiter

Overview:
- Two-requester arbiter that sits directly upstream of bp2wb_convertor.
- Merges the BP core memory port (port 0) and the BP I/O port (port 1) onto the single cce mem cmd/resp channel the convertor consumes.
- Only one transaction is outstanding at a time. Responses are routed back to the owning requester.
- A response-timeout watchdog flags hung Wishbone accesses.

Parameters:
- bp_params_p, e_bp_single_core_cfg, BP configuration; cce_mem_msg_width_lp is derived from it through the standard declare macros.
- timeout_cycles_p, 4096, cycles from downstream cmd handoff to response before timeout_o is set; must be ≥2.
- timeout_ctr_width_lp (localparam), `BSG_SAFE_CLOG2(timeout_cycles_p+1), width of the watchdog counter.

Ports:
- clk_i  in  1  sole clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- mem_cmd_i  in  2 x cce_mem_msg_width_lp  request commands, index 0 = core, 1 = I/O.
- mem_cmd_v_i  in  2  per-requester cmd valid.
- mem_cmd_ready_o  out  2  per-requester cmd ready.
- mem_resp_o  out  cce_mem_msg_width_lp  response message, shared by both requesters.
- mem_resp_v_o  out  2  per-requester resp valid.
- mem_resp_yumi_i  in  2  per-requester resp consume.
- mem_cmd_o  out  cce_mem_msg_width_lp  command to convertor.
- mem_cmd_v_o  out  1  command valid to convertor.
- mem_cmd_ready_i  in  1  convertor ready.
- mem_resp_i  in  cce_mem_msg_width_lp  response from convertor.
- mem_resp_v_i  in  1  convertor resp valid.
- mem_resp_yumi_o  out  1  consume to convertor.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
Reset (asynchronous, applies immediately, any state):
- state=IDLE, last_grant=1 (port 0 wins first), owner=0, cmd_r=0, timeout counter=0, timeout_o=0.
- All ready/valid/yumi outputs are 0 while reset_i is high.
- Reset mid-transaction drops the transaction; the next command is accepted fresh.

IDLE:
- Grant g = the valid port. If both ports are valid, g = !last_grant.
- mem_cmd_ready_o[g] = 1 combinationally; the other bit is 0.
- On mem_cmd_v_i[g]: latch mem_cmd_i[g] into cmd_r, owner<=g, last_grant<=g, go to SEND.
- The grant is not sticky: if the request drops before handshake, re-arbitrate the next cycle.

SEND:
- mem_cmd_o = cmd_r.
- mem_cmd_v_o = mem_cmd_ready_i. The convertor latches on v alone, so v is never raised without ready.
- On mem_cmd_v_o=1: go to WAIT and clear the timeout counter.
- Earliest downstream valid is 1 cycle after requester handshake.
- mem_cmd_ready_o=0 in SEND and WAIT.

WAIT:
- mem_resp_o = mem_resp_i (combinational, zero latency).
- mem_resp_v_o[owner] = mem_resp_v_i; the other bit is 0.
- mem_resp_yumi_o = mem_resp_yumi_i[owner] & mem_resp_v_i. A yumi from the non-owner is ignored.
- On mem_resp_yumi_o: go to IDLE.
- A new cmd can be accepted in the cycle after the yumi cycle; there is no same-cycle overlap.

Watchdog:
- The counter increments every cycle in WAIT and saturates at timeout_cycles_p.
- When it reaches timeout_cycles_p, set timeout_o=1. The flag stays set until reset.
- The FSM remains in WAIT after a timeout. A late response still completes normally.

mem_cmd_o:
- Outside SEND it holds cmd_r; the value is don't-care when v=0 but stable.

Spurious input:
- mem_resp_v_i in IDLE or SEND is a protocol violation. It is not forwarded and not consumed.
- The simulation build flags it with an assertion.

Decomposition:
- Shared package (bp2wb_pkg):
  - the state enum (e_arb_idle, e_arb_send, e_arb_wait);
  - the default timeout constant;
  - port index constants (core=0, io=1).
- The bp_cce_mem_msg_s type comes from the existing me_if declare macro and is not redefined.
- One natural sub-module: bp_mem_rr_arb2, a 2-input round-robin grant with a last_grant register and a grant-accepted update input.
- The rest (FSM, cmd register, resp routing, watchdog) stays in the top.

Test Plan:
1. Single request: port0 issues a read to 0x8000_0000 with ready_i=1.
   - mem_cmd_v_o=1 exactly 1 cycle after handshake with header.addr=0x8000_0000.
   - The response returns on mem_resp_v_o=2'b01 with identical data.
   - Back to IDLE 1 cycle after yumi.
2. Contention: both ports valid continuously for 4 transactions.
   - Grants alternate 0,1,0,1.
   - mem_resp_v_o bits match the owners in the same order.
3. Backpressure: mem_cmd_ready_i held low 10 cycles after handshake.
   - mem_cmd_v_o stays 0 for 10 cycles, then is 1 for exactly one cycle when ready rises.
4. Response stall: resp_v_i held 3 cycles with owner yumi low, port1 yumi high.
   - mem_resp_yumi_o stays 0 until owner yumi.
   - Port1 never sees valid.
5. Timeout: timeout_cycles_p=16, no response.
   - timeout_o rises 16 cycles after cmd handoff and stays high.
   - A response at cycle 30 still completes and the FSM returns to IDLE.
6. Async reset asserted mid-WAIT, between clock edges.
   - All outputs are 0 immediately and timeout_o is cleared.
   - The first post-reset request (from port 1 alone) is granted.
